// File: rtl/qar_dmem_if.sv
// qar_dmem_if -- data-port handshake between qar_core and its memory bridge.
//
// Signals:
//   mem_valid  core -> bridge  request, held high until mem_ready is seen
//   mem_we     core -> bridge  1 = write, 0 = read
//   mem_addr   core -> bridge  byte address
//   mem_wdata  core -> bridge  write data
//   mem_ready  bridge -> core  one-cycle completion pulse
//   mem_rdata  bridge -> core  read data, valid while mem_ready = 1
//   mem_err    bridge -> core  access rejected, valid while mem_ready = 1
//
// Modports: master = core side, slave = bridge side.
interface qar_dmem_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata, mem_err
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata, mem_err
    );
endinterface

// File: rtl/qar_dmem_bridge.sv
// qar_dmem_bridge -- turns qar_core's level-held data request into one access
// on a single-port synchronous SRAM (1-cycle read latency), with programmable
// wait states, address-window/alignment checking and saturating counters.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   mem           qar_dmem_if.slave: core request / response
//   sram_en       SRAM access strobe (high only in ACCESS)
//   sram_we       SRAM write enable, qualified by sram_en
//   sram_addr     SRAM word address
//   sram_wdata    SRAM write data
//   sram_rdata    SRAM read data, valid the cycle after a read strobe
//   access_count  completed good accesses, saturating
//   err_count     rejected accesses, saturating
module qar_dmem_bridge #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    qar_dmem_if.slave             mem,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic [15:0]           access_count,
    output logic [15:0]           err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_WAIT,
        S_RESP
    } state_t;

    // Good path enters WAIT after CAPTURE and must spend WAIT_STATES cycles
    // there. The error path enters WAIT straight from IDLE; its first WAIT
    // cycle stands in for the missing ACCESS/CAPTURE turnaround, so it spends
    // WAIT_STATES+1 cycles there.
    localparam logic [3:0] WAIT_LOAD_GOOD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [3:0] WAIT_LOAD_ERR  = 4'(WAIT_STATES);

    state_t                  state_q, state_d;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic                    err_q;
    logic [31:0]             rdata_q;
    logic [3:0]              wait_q;

    // Decode is done on the live address in IDLE; it is the same value that
    // gets latched on that edge, so the routing decision and the latch agree.
    logic in_range;
    logic aligned;
    logic req_good;
    logic req_take;

    assign in_range = (mem.mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign aligned  = (mem.mem_addr[1:0] == 2'b00);
    assign req_good = in_range && aligned;
    assign req_take = (state_q == S_IDLE) && mem.mem_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (mem.mem_valid) state_d = req_good ? S_ACCESS : S_WAIT;
            S_ACCESS:  state_d = S_CAPTURE;
            S_CAPTURE: state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:    if (wait_q == 4'd0) state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registers only (no path from mem_* inputs)
    // ------------------------------------------------------------------
    always_comb begin
        sram_en       = 1'b0;
        sram_we       = 1'b0;
        mem.mem_ready = 1'b0;
        mem.mem_err   = 1'b0;
        mem.mem_rdata = 32'h0;
        if (state_q == S_ACCESS) begin
            sram_en = 1'b1;
            sram_we = we_q;
        end
        if (state_q == S_RESP) begin
            mem.mem_ready = 1'b1;
            mem.mem_err   = err_q;
            mem.mem_rdata = (err_q || we_q) ? 32'h0 : rdata_q;
        end
    end

    assign sram_addr  = idx_q;
    assign sram_wdata = wdata_q;

    // ------------------------------------------------------------------
    // Request capture: only in IDLE, so later changes on the bus are ignored
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (req_take) begin
            we_q    <= mem.mem_we;
            idx_q   <= mem.mem_addr[ADDR_WIDTH+1:2];
            wdata_q <= mem.mem_wdata;
            err_q   <= !req_good;
        end
    end

    // Read data is valid in CAPTURE (one cycle after the ACCESS strobe).
    always_ff @(posedge clk) begin
        if (rst)                       rdata_q <= 32'h0;
        else if (state_q == S_CAPTURE) rdata_q <= we_q ? 32'h0 : sram_rdata;
    end

    // Wait-state down-counter; WAIT exits on the cycle it reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= 4'd0;
        end else if (req_take && !req_good) begin
            wait_q <= WAIT_LOAD_ERR;
        end else if (state_q == S_CAPTURE) begin
            wait_q <= WAIT_LOAD_GOOD;
        end else if (state_q == S_WAIT && wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating bring-up counters, bumped once per RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            access_count <= 16'h0;
            err_count    <= 16'h0;
        end else if (state_q == S_RESP) begin
            if (err_q) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end else begin
                if (access_count != 16'hFFFF) access_count <= access_count + 16'd1;
            end
        end
    end

endmodule
